clk_en_gen: RTL and testbench

Parametrised multi-channel clock-enable generator for the CPU top level. It replaces the fixed free-running dividers with NCH independent channels, each with a run-time programmable divide ratio, run/stop/single-step modes, a one-cycle enable pulse and a 50%-duty toggle output. All channels run on the board clock. CPU, instruction-memory and display logic consume the enable pulses or toggle levels, so no derived clocks are needed.

---
 rtl/clk_en_gen.sv | 100 ++++++++++
 tb/tb_clk_en_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divider with
// run/stop/step modes, one-cycle enable pulse and 50%-duty toggle level.
module clk_en_gen #(
  parameter int unsigned          NCH       = 2,
  parameter int unsigned          CNT_W     = 31,
  parameter logic [NCH*CNT_W-1:0] DIV_INIT  = {NCH{CNT_W'(100)}},
  parameter logic [NCH-1:0]       TCK_INIT  = '0,
  parameter logic [2*NCH-1:0]     MODE_INIT = {NCH{2'b01}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*CNT_W-1:0] div_i,
  input  logic [NCH-1:0]       load_i,
  input  logic [2*NCH-1:0]     mode_i,
  input  logic [NCH-1:0]       step_i,
  output logic [NCH-1:0]       en_o,
  output logic [NCH-1:0]       tck_o,
  output logic [NCH-1:0]       busy_o
);

  localparam logic [1:0] MODE_STEP = 2'b10;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_en;
    logic             r_tck;
    logic [1:0]       r_mode;

    logic [CNT_W-1:0] w_div;
    logic [CNT_W-1:0] w_last;
    logic             w_wrap;
    logic             w_run;
    logic             w_step;
    logic             w_load;

    assign w_div  = div_i[g*CNT_W +: CNT_W];
    // Last count of the period; a zero divide value behaves as divide-by-one.
    assign w_last = (r_div_act == '0) ? '0 : r_div_act - CNT_W'(1);
    assign w_wrap = (r_cnt == w_last);
    // Mode 11 is treated as run, so bit 0 alone selects run.
    assign w_run  = r_mode[0];
    assign w_step = (r_mode == MODE_STEP);
    assign w_load = load_i[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt      <= '0;
        r_div_act  <= DIV_INIT[g*CNT_W +: CNT_W];
        r_div_pend <= '0;
        r_pend     <= 1'b0;
        r_en       <= 1'b0;
        r_tck      <= TCK_INIT[g];
        r_mode     <= MODE_INIT[2*g +: 2];
      end else begin
        r_mode <= mode_i[2*g +: 2];
        r_en   <= 1'b0;
        if (w_run) begin
          if (w_wrap) begin
            r_cnt <= '0;
            r_en  <= 1'b1;
            r_tck <= ~r_tck;
            // A load landing on the wrap beats any older pending value.
            if (w_load) begin
              r_div_act <= w_div;
            end else if (r_pend) begin
              r_div_act <= r_div_pend;
            end
            r_pend <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_load) begin
              r_div_pend <= w_div;
              r_pend     <= 1'b1;
            end
          end
        end else begin
          if (w_step && step_i[g]) begin
            r_en  <= 1'b1;
            r_tck <= ~r_tck;
            r_cnt <= '0;
          end
          // Outside run mode a load applies at once and restarts the count.
          if (w_load) begin
            r_div_act <= w_div;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
          end
        end
      end
    end

    assign en_o[g]   = r_en;
    assign tck_o[g]  = r_tck;
    assign busy_o[g] = r_pend;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: a default 2-channel build plus a 1-channel
// CNT_W=4 build for the counter-compare boundary.
module tb_clk_en_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [61:0] div_i;
  logic [1:0]  load_i;
  logic [3:0]  mode_i;
  logic [1:0]  step_i;
  logic [1:0]  en_o;
  logic [1:0]  tck_o;
  logic [1:0]  busy_o;

  logic [3:0]  div4;
  logic        load4;
  logic [1:0]  mode4;
  logic        step4;
  logic        en4;
  logic        tck4;
  logic        busy4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  clk_en_gen dut (
    .clk    (clk),
    .rst    (rst),
    .div_i  (div_i),
    .load_i (load_i),
    .mode_i (mode_i),
    .step_i (step_i),
    .en_o   (en_o),
    .tck_o  (tck_o),
    .busy_o (busy_o)
  );

  clk_en_gen #(
    .NCH       (1),
    .CNT_W     (4),
    .DIV_INIT  (4'd15),
    .TCK_INIT  (1'b0),
    .MODE_INIT (2'b01)
  ) dut4 (
    .clk    (clk),
    .rst    (rst),
    .div_i  (div4),
    .load_i (load4),
    .mode_i (mode4),
    .step_i (step4),
    .en_o   (en4),
    .tck_o  (tck4),
    .busy_o (busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the next enable pulse on a channel (sel4 picks the CNT_W=4 build).
  task automatic gap(input bit sel4, input bit ch, input int bound, output int n);
    logic e;
    n = 0;
    do begin
      tick();
      n++;
      e = sel4 ? en4 : en_o[ch];
    end while (!e && n < bound);
  endtask

  // Stop a channel, then load a divide value directly (count restarts at 0).
  task automatic stop_load(input bit ch, input logic [30:0] v);
    if (ch) mode_i[3:2] = 2'b00;
    else    mode_i[1:0] = 2'b00;
    tick();
    if (ch) div_i[61:31] = v;
    else    div_i[30:0]  = v;
    load_i[ch] = 1'b1;
    tick();
    load_i[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt_en;
    int cnt_tg;
    logic t_prev;
    logic [6:0] step_pat;

    rst = 1'b1; div_i = '0; load_i = '0; mode_i = 4'b0101; step_i = '0;
    div4 = '0; load4 = 1'b0; mode4 = 2'b01; step4 = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_tck", 32'(tck_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // Default run: pulses every 100 edges, toggle follows.
    gap(1'b0, 1'b0, 200, n); chk("run_gap1", 32'(n), 32'd100);
    chk("run_en_both", 32'(en_o), 32'd3);
    chk("run_tck1", 32'(tck_o[0]), 32'd1);
    gap(1'b0, 1'b0, 200, n); chk("run_gap2", 32'(n), 32'd100);
    chk("run_tck2", 32'(tck_o[0]), 32'd0);
    gap(1'b0, 1'b0, 200, n); chk("run_gap3", 32'(n), 32'd100);
    chk("run_tck3", 32'(tck_o[0]), 32'd1);
    chk("run_busy", 32'(busy_o), 32'd0);

    // Deferred load to 10, then load 4 at cnt=3.
    div_i[30:0] = 31'd10; load_i[0] = 1'b1; tick(); load_i[0] = 1'b0;
    chk("defer10_busy", 32'(busy_o[0]), 32'd1);
    gap(1'b0, 1'b0, 200, n); chk("defer10_rest", 32'(n), 32'd99);
    chk("defer10_clr", 32'(busy_o[0]), 32'd0);
    gap(1'b0, 1'b0, 200, n); chk("div10_gap", 32'(n), 32'd10);
    repeat (3) tick();
    div_i[30:0] = 31'd4; load_i[0] = 1'b1; tick(); load_i[0] = 1'b0;
    chk("defer4_busy", 32'(busy_o[0]), 32'd1);
    gap(1'b0, 1'b0, 200, n); chk("defer4_rest", 32'(n), 32'd6);
    chk("defer4_clr", 32'(busy_o[0]), 32'd0);
    gap(1'b0, 1'b0, 200, n); chk("div4_gap", 32'(n), 32'd4);

    // Load coincident with the wrap.
    div_i[30:0] = 31'd5; load_i[0] = 1'b1; tick(); load_i[0] = 1'b0;
    gap(1'b0, 1'b0, 200, n); chk("to5_rest", 32'(n), 32'd3);
    repeat (4) tick();
    chk("wrap_pre_en", 32'(en_o[0]), 32'd0);
    div_i[30:0] = 31'd3; load_i[0] = 1'b1; tick(); load_i[0] = 1'b0;
    chk("wrap_en", 32'(en_o[0]), 32'd1);
    chk("wrap_busy", 32'(busy_o[0]), 32'd0);
    gap(1'b0, 1'b0, 200, n); chk("wrap_next_gap", 32'(n), 32'd3);
    chk("wrap_busy2", 32'(busy_o[0]), 32'd0);

    // div=0 and div=1: pulse and toggle every edge.
    for (int k = 0; k < 2; k++) begin
      stop_load(1'b1, 31'(k));
      chk("edge_busy", 32'(busy_o[1]), 32'd0);
      mode_i[3:2] = 2'b01; tick();
      cnt_en = 0; cnt_tg = 0;
      for (int j = 0; j < 4; j++) begin
        t_prev = tck_o[1];
        tick();
        if (en_o[1]) cnt_en++;
        if (tck_o[1] != t_prev) cnt_tg++;
      end
      chk("edge_en_cnt", 32'(cnt_en), 32'd4);
      chk("edge_tg_cnt", 32'(cnt_tg), 32'd4);
    end

    // Maximum divide value: no pulse soon after the count restarts.
    stop_load(1'b1, 31'h7FFF_FFFF);
    mode_i[3:2] = 2'b01; tick();
    cnt_en = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (en_o[1]) cnt_en++;
    end
    chk("maxdiv_no_en", 32'(cnt_en), 32'd0);

    // Stop at cnt=6 for 20 edges, then resume.
    stop_load(1'b0, 31'd10);
    mode_i[1:0] = 2'b01; tick();
    repeat (5) tick();
    mode_i[1:0] = 2'b00; tick();
    t_prev = tck_o[0];
    cnt_en = 0; cnt_tg = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (en_o[0]) cnt_en++;
      if (tck_o[0] != t_prev) cnt_tg++;
    end
    chk("stop_no_en", 32'(cnt_en), 32'd0);
    chk("stop_tck_hold", 32'(cnt_tg), 32'd0);
    mode_i[1:0] = 2'b01; tick();
    gap(1'b0, 1'b0, 200, n); chk("resume_gap", 32'(n), 32'd4);

    // Step mode: requests on cycles 0, 1, 5.
    mode_i[1:0] = 2'b10; tick();
    step_pat = 7'b0100011;
    cnt_tg = 0;
    for (int j = 0; j < 7; j++) begin
      step_i[0] = step_pat[j];
      t_prev = tck_o[0];
      tick();
      chk("step_en", 32'(en_o[0]), 32'(step_pat[j]));
      if (tck_o[0] != t_prev) cnt_tg++;
    end
    step_i[0] = 1'b0;
    chk("step_toggles", 32'(cnt_tg), 32'd3);

    // Reset mid-count with a pending load (cnt=7).
    stop_load(1'b0, 31'd10);
    mode_i = 4'b0101; tick();
    repeat (6) tick();
    div_i[30:0] = 31'd3; load_i[0] = 1'b1; tick(); load_i[0] = 1'b0;
    chk("mid_busy", 32'(busy_o[0]), 32'd1);
    rst = 1'b1; load_i = 2'b11; step_i = 2'b11; div_i = '0;
    tick();
    rst = 1'b0; load_i = '0; step_i = '0;
    chk("mid_rst_en", 32'(en_o), 32'd0);
    chk("mid_rst_tck", 32'(tck_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);

    // Reduced CNT_W=4 build at divide 15, then the 100-edge restart on the main build.
    gap(1'b1, 1'b0, 100, n); chk("w4_gap1", 32'(n), 32'd15);
    gap(1'b1, 1'b0, 100, n); chk("w4_gap2", 32'(n), 32'd15);
    chk("w4_tck", 32'(tck4), 32'd0);
    gap(1'b0, 1'b0, 200, n); chk("mid_restart_gap", 32'(n), 32'd70);
    chk("mid_restart_en", 32'(en_o), 32'd3);
    chk("mid_restart_tck", 32'(tck_o), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
